// File: rtl/axil_reg_master.sv
// axil_reg_master: AXI4-Lite master that runs one 32-bit register read or write
// per command, with a valid/ready command port and a valid/ready response port.
// Optional build macro: AXIL_MASTER_TIMEOUT_EN. When it is defined, each wait phase
// aborts after C_TIMEOUT cycles, and BREADY/RREADY stay high in IDLE to drain late
// responses.
module axil_reg_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT          = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  // command port
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_rnw,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response port
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                            rsp_err,
  // AXI4-Lite master
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_RSP
  } state_t;

  state_t                            r_state, w_next;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     r_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_wdata;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   r_wstrb;
  logic                              r_aw_done, r_w_done;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_rdata;
  logic                              r_err;
  logic                              w_cmd_hs, w_aw_hs, w_w_hs, w_timeout;

  assign w_cmd_hs = cmd_valid && cmd_ready;
  assign w_aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_w_hs   = M_AXI_WVALID && M_AXI_WREADY;

  // Payload is registered at command accept so it stays constant while VALID is high.
  assign M_AXI_AWADDR = r_addr;
  assign M_AXI_ARADDR = r_addr;
  assign M_AXI_WDATA  = r_wdata;
  assign M_AXI_WSTRB  = r_wstrb;
  assign rsp_rdata    = r_rdata;
  assign rsp_err      = r_err;

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic [15:0] r_tcnt;
  logic        w_waiting;

  assign w_waiting = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                     (r_state == S_RD_REQ) || (r_state == S_RD_RESP);
  assign w_timeout = w_waiting && (r_tcnt == 16'(C_TIMEOUT - 1));

  // Per-phase watchdog: cleared on every state change, counts while waiting on the slave.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_tcnt <= '0;
    else if (w_next != r_state) r_tcnt <= '0;
    else if (w_waiting)         r_tcnt <= r_tcnt + 16'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and handshake outputs; a real slave response beats a same-cycle timeout.
  always_comb begin
    // NOTE: every output gets a default here so no path leaves one unassigned (no latch).
    w_next        = r_state;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = !reset;
`ifdef AXIL_MASTER_TIMEOUT_EN
        M_AXI_BREADY = !reset;
        M_AXI_RREADY = !reset;
`endif
        if (cmd_valid && !reset) w_next = cmd_rnw ? S_RD_REQ : S_WR_REQ;
      end
      S_WR_REQ: begin
        M_AXI_AWVALID = !r_aw_done;
        M_AXI_WVALID  = !r_w_done;
        if ((r_aw_done || M_AXI_AWREADY) && (r_w_done || M_AXI_WREADY)) w_next = S_WR_RESP;
        else if (w_timeout)                                              w_next = S_RSP;
      end
      S_WR_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID)   w_next = S_RSP;
        else if (w_timeout) w_next = S_RSP;
      end
      S_RD_REQ: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY)  w_next = S_RD_RESP;
        else if (w_timeout) w_next = S_RSP;
      end
      S_RD_RESP: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID)   w_next = S_RSP;
        else if (w_timeout) w_next = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch, per-channel write completion flags and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_cmd_hs) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (r_state == S_WR_RESP && M_AXI_BVALID) begin
        r_rdata <= '0;
        r_err   <= (M_AXI_BRESP != 2'b00);
      end else if (r_state == S_RD_RESP && M_AXI_RVALID) begin
        r_rdata <= M_AXI_RDATA;
        r_err   <= (M_AXI_RRESP != 2'b00);
      end else if (w_timeout && w_next == S_RSP) begin
        r_rdata <= C_M_AXI_DATA_WIDTH'(32'hDEAD_BEEF);
        r_err   <= 1'b1;
      end
    end
  end

endmodule
